// File: rtl/vp_input_pkg.sv
// ---------------------------------------------------------------------------
// vp_input_pkg
// Shared types for the Videopac key input path.
//   key_event_t : one queued key event {released, ascii}
//   key_ascii() : keypad button index -> ASCII code handed to vp_keymap
//   out_state_e : presentation state machine encoding
// ---------------------------------------------------------------------------
package vp_input_pkg;

  typedef struct packed {
    logic       released;
    logic [7:0] ascii;
  } key_event_t;

  // Value the presentation register holds out of reset: "no key, released".
  localparam key_event_t EV_RESET = '{released: 1'b1, ascii: 8'h00};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    WAIT   = 2'd2,
    GAP    = 2'd3
  } out_state_e;

  function automatic logic [7:0] key_ascii(input logic [3:0] k);
    logic [7:0] a;
    case (k)
      4'd0:    a = 8'h31;  // "1"
      4'd1:    a = 8'h32;
      4'd2:    a = 8'h33;
      4'd3:    a = 8'h34;
      4'd4:    a = 8'h35;
      4'd5:    a = 8'h36;
      4'd6:    a = 8'h37;
      4'd7:    a = 8'h38;
      4'd8:    a = 8'h39;  // "9"
      4'd9:    a = 8'h30;  // "0"
      4'd10:   a = 8'h2B;  // "+"
      4'd11:   a = 8'h2D;  // "-"
      4'd12:   a = 8'h2A;  // "*"
      4'd13:   a = 8'h2F;  // "/"
      4'd14:   a = 8'h3D;  // "="
      default: a = 8'd10;  // enter
    endcase
    return a;
  endfunction

endpackage

// File: rtl/vp_event_fifo.sv
// ---------------------------------------------------------------------------
// vp_event_fifo
// Synchronous show-ahead FIFO of key_event_t.
//   clk_sys, reset : clock, async active-high reset
//   push_i, data_i : write request and data; accepted when not full, or when
//                    full and a pop happens in the same cycle
//   pop_i, data_o  : read request; data_o shows the head entry
//   full_o, empty_o, count_o : occupancy status
// ---------------------------------------------------------------------------
module vp_event_fifo
  import vp_input_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   push_i,
  input  key_event_t             data_i,
  input  logic                   pop_i,
  output key_event_t             data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  key_event_t      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_sys) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/vp_key_event_queue.sv
// ---------------------------------------------------------------------------
// vp_key_event_queue
// Merges the keypads of NUM_JOY joysticks, turns net per-key state changes
// into press/release events, queues them, and presents them one at a time to
// vp_keymap with a strobe / acknowledge handshake.
//
// Build option: VP_PS2_MERGE_EN adds the ps2_* ports and merges translated
// PS/2 events into the queue ahead of the keypad scanner.
//
// Ports
//   clk_sys, reset      : clock, async active-high reset
//   joy_keys_i          : key levels, joystick j at [j*NUM_KEYS +: NUM_KEYS]
//   ps2_stb_i/ascii_i/released_i : PS/2 event input (VP_PS2_MERGE_EN only)
//   rx_data_ready_o     : one-cycle event strobe
//   rx_ascii_o          : event code, held until the next strobe
//   rx_released_o       : 1 = release event, held until the next strobe
//   rx_read_i           : acknowledge, only honoured while waiting for it
//   count_o             : FIFO occupancy
//   overflow_o          : sticky, a PS/2 event was dropped on a full FIFO
//
// Presentation FSM
//   state  | meaning
//   IDLE   | waiting for a queued event; pops it into the output register
//   STROBE | rx_data_ready_o high for this single cycle
//   WAIT   | waiting for rx_read_i, bounded by ACK_TIMEOUT cycles
//   GAP    | GAP_CYCLES forced idle cycles before the next event
// ---------------------------------------------------------------------------
module vp_key_event_queue
  import vp_input_pkg::*;
#(
  parameter int NUM_JOY     = 2,
  parameter int NUM_KEYS    = 10,
  parameter int FIFO_DEPTH  = 8,
  parameter int ACK_TIMEOUT = 64,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  input  logic [NUM_JOY*NUM_KEYS-1:0]   joy_keys_i,
`ifdef VP_PS2_MERGE_EN
  input  logic                          ps2_stb_i,
  input  logic [7:0]                    ps2_ascii_i,
  input  logic                          ps2_released_i,
`endif
  output logic                          rx_data_ready_o,
  output logic [7:0]                    rx_ascii_o,
  output logic                          rx_released_o,
  input  logic                          rx_read_i,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          overflow_o
);

  localparam int IDXW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int TMAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  generate
    if (NUM_KEYS < 1 || NUM_KEYS > 16) begin : g_bad_keys
      $error("vp_key_event_queue: NUM_KEYS must be 1..16");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("vp_key_event_queue: FIFO_DEPTH must be a power of two >= 2");
    end
    if (ACK_TIMEOUT < 1) begin : g_bad_ack
      $error("vp_key_event_queue: ACK_TIMEOUT must be >= 1");
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Key merge and scanner
  // -------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] merged;
  logic [NUM_KEYS-1:0] prev_q, prev_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic                scan_change;

  always_comb begin
    merged = '0;
    for (int j = 0; j < NUM_JOY; j++) begin
      merged = merged | joy_keys_i[j*NUM_KEYS +: NUM_KEYS];
    end
  end

  assign scan_change = (merged[idx_q] != prev_q[idx_q]);

  // -------------------------------------------------------------------------
  // PS/2 source
  // -------------------------------------------------------------------------
  logic       ps2_req;
  key_event_t ps2_ev;

`ifdef VP_PS2_MERGE_EN
  assign ps2_req = ps2_stb_i;
  assign ps2_ev  = '{released: ps2_released_i, ascii: ps2_ascii_i};
`else
  assign ps2_req = 1'b0;
  assign ps2_ev  = EV_RESET;
`endif

  // -------------------------------------------------------------------------
  // FIFO
  // -------------------------------------------------------------------------
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic       slot_free;
  key_event_t push_ev, head_ev;

  // A slot frees up in the same cycle the presentation FSM pops.
  assign slot_free = !fifo_full || fifo_pop;

  always_comb begin
    fifo_push = 1'b0;
    push_ev   = '{released: ~merged[idx_q], ascii: key_ascii(4'(idx_q))};
    prev_d    = prev_q;
    idx_d     = (idx_q == IDXW'(NUM_KEYS - 1)) ? '0 : idx_q + IDXW'(1);
    if (ps2_req) begin
      // The scanner yields the whole cycle so the pending key is revisited
      // immediately afterwards rather than one full scan later.
      idx_d = idx_q;
      if (slot_free) begin
        fifo_push = 1'b1;
        push_ev   = ps2_ev;
      end
    end else if (scan_change && slot_free) begin
      fifo_push      = 1'b1;
      prev_d[idx_q]  = merged[idx_q];
    end
    // With no free slot prev is left alone, so the change is retried later.
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
      idx_q  <= '0;
    end else begin
      prev_q <= prev_d;
      idx_q  <= idx_d;
    end
  end

  vp_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push_i  (fifo_push),
    .data_i  (push_ev),
    .pop_i   (fifo_pop),
    .data_o  (head_ev),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count_o)
  );

`ifdef VP_PS2_MERGE_EN
  logic overflow_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (ps2_req && !slot_free) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow_o = overflow_q;
`else
  // The scanner stalls rather than drops, so nothing can overflow.
  assign overflow_o = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Presentation FSM
  // -------------------------------------------------------------------------
  out_state_e    state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  key_event_t    rx_ev_q, rx_ev_d;

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    rx_ev_d  = rx_ev_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          rx_ev_d  = head_ev;
          state_d  = STROBE;
        end
      end
      STROBE: begin
        state_d = WAIT;
        tmr_d   = TW'(ACK_TIMEOUT - 1);
      end
      WAIT: begin
        if (rx_read_i || tmr_q == '0) begin
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            tmr_d   = TW'(GAP_CYCLES - 1);
          end
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      GAP: begin
        if (tmr_q == '0) begin
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      rx_ev_q <= EV_RESET;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      rx_ev_q <= rx_ev_d;
    end
  end

  assign rx_data_ready_o = (state_q == STROBE);
  assign rx_ascii_o      = rx_ev_q.ascii;
  assign rx_released_o   = rx_ev_q.released;

endmodule

// File: doc/vp_key_event_queue.md
# vp_key_event_queue

Parametrised joystick-keypad and PS/2 key event queue for the Videopac console top level. It sits between the raw controller inputs and `vp_keymap`. It detects press and release edges per key, merged across any number of joysticks, and buffers them in a FIFO. Events are presented one at a time using the `vp_keymap` strobe/acknowledge handshake, so simultaneous or rapid keypad presses are no longer lost or left stuck.

## Interface
Parameters:
- `NUM_JOY`, 2: number of joystick channels merged.
- `NUM_KEYS`, 10: keypad buttons per joystick, 1..16. Key k maps to `vp_input_pkg::key_ascii(k)`.
- `FIFO_DEPTH`, 8: event entries, power of two, ≥2.
- `ACK_TIMEOUT`, 64: maximum cycles spent waiting for `rx_read_i`.
- `GAP_CYCLES`, 4: idle cycles forced between two presented events.

Ports:
- `clk_sys` in 1: system clock. The block has one clock.
- `reset` in 1: asynchronous, active-high reset.
- `joy_keys_i` in NUM_JOY*NUM_KEYS: 1 = pressed. Bits [j*NUM_KEYS +: NUM_KEYS] belong to joystick j. Synchronous to `clk_sys`.
- `ps2_stb_i` in 1: one-cycle strobe for a translated PS/2 event. Present only with the macro.
- `ps2_ascii_i` in 8: ASCII code of the PS/2 event. Present only with the macro.
- `ps2_released_i` in 1: 1 = PS/2 key release. Present only with the macro.
- `rx_data_ready_o` out 1: one-cycle event strobe to `vp_keymap`.
- `rx_ascii_o` out 8: event ASCII code. Held stable until the next strobe.
- `rx_released_o` out 1: 1 = release event. Held stable until the next strobe.
- `rx_read_i` in 1: acknowledge from `vp_keymap`.
- `count_o` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `overflow_o` out 1: sticky flag, set when a PS/2 event is dropped.

## Operation
Key merge and edge detection:
- `merged[k]` = OR of key k over all joysticks.
- Register `prev[k]` holds the last state that was queued for key k.

Scanner:
- Index `idx` steps 0..NUM_KEYS-1 and wraps to 0, one key per cycle.
- If `merged[idx] != prev[idx]` and a push slot is available, push {released=~merged[idx], ascii=key_ascii(idx)} and set `prev[idx] <= merged[idx]`.
- If no slot is available, `prev` is left unchanged. The event is retried on a later scan, so joystick events are never lost.
- A press and release that both fall between two visits of the same key cancel out. Only net state changes are queued.

PS/2 path (macro only):
- `ps2_stb_i` has push priority over the scanner.
- In a PS/2 push cycle the scanner does not push and `idx` does not advance.
- A PS/2 event arriving while the FIFO is full is dropped and `overflow_o` is set to 1.

FIFO:
- A push is accepted if not full, or if full and a pop occurs in the same cycle.
- A simultaneous push and pop leaves `count_o` unchanged.

Output state machine:
- IDLE: if the FIFO is non-empty, pop it, register the event onto `rx_ascii_o`/`rx_released_o`, then go to STROBE.
- STROBE: `rx_data_ready_o` is 1 for exactly this cycle, then go to WAIT.
- WAIT: exit to GAP when `rx_read_i` is 1, or after ACK_TIMEOUT cycles in WAIT, whichever comes first.
- GAP: stay GAP_CYCLES cycles, then go to IDLE.
- An `rx_read_i` asserted outside WAIT is ignored.

## Timing
Reset values, applied immediately on asynchronous `reset`:
- `rx_data_ready_o` = 0, `rx_ascii_o` = 8'h00, `rx_released_o` = 1.
- `count_o` = 0, `overflow_o` = 0.
- `prev` = 0, `idx` = 0, state = IDLE.

Latencies:
- Key change to FIFO push: 1..NUM_KEYS cycles while the FIFO has space.
- Non-empty FIFO in IDLE to `rx_data_ready_o`: 1 cycle.
- Minimum spacing between strobes: 3 + GAP_CYCLES cycles, when `rx_read_i` is returned in the first WAIT cycle.

Reset mid-operation:
- Queued events are discarded.
- Because `prev` returns to 0, keys still held after reset are re-queued as press events.

## Configuration
`VP_PS2_MERGE_EN`:
- Defined: the PS/2 ports exist and the PS/2 path merges into the FIFO with priority over the scanner.
- Undefined: the PS/2 ports are absent and the FIFO is fed only by the scanner. `overflow_o` is tied to 0, since the scanner stalls instead of dropping events.

## Structure
- Package `vp_input_pkg` contains:
  - `key_event_t` packed struct {released, ascii[7:0]}.
  - `key_ascii()` LUT: 0..9 → "1".."9","0"; 10..15 → "+","-","*","/","=",8'd10.
  - Output state enum {IDLE, STROBE, WAIT, GAP}.
- Sub-module `vp_event_fifo`: synchronous FIFO of `key_event_t` with push, pop, full, empty and count.

## Test plan
- Joystick 0 key 0 pressed, `rx_read_i` returned 3 cycles after the strobe, then key released: exactly two strobes, 8'h31/released=0 followed by 8'h31/released=1.
- Joystick 0 and joystick 1 both hold key 4 with overlapping presses: exactly one 8'h35 press, and one 8'h35 release only after both joysticks have released.
- All 10 keys pressed in one cycle, FIFO_DEPTH=8, `rx_read_i` tied 0: ten strobes spaced by the ACK_TIMEOUT path, ASCII in order "1".."9","0", none lost, `count_o` never exceeds 8.
- With the macro, `ps2_stb_i` with 8'h61 in the same cycle as a pending scanner event: 8'h61 is queued first and `idx` holds for that cycle.
- With the macro, FIFO full (`count_o` = 8) and `ps2_stb_i` asserted: `overflow_o` becomes 1 and stays 1, and `count_o` stays 8.
- `reset` asserted during WAIT while key 2 is held: outputs go to their reset values at once, and a fresh 8'h33 press is strobed after reset is released.
